// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the core reset; re-runs the sequence on lock timeout or lock loss.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_locked_s;
  logic             w_relock_inc;
  logic             w_timeout_inc;
  logic             r_pll_rst;
  logic             r_core_reset;
  logic             r_ready;
  logic [7:0]       r_relock_count;
  logic [7:0]       r_timeout_count;

  // pll_locked comes from another clock domain; only r_locked_s may be used below.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values,
      // which is what lets r_sync1 -> r_locked_s form a true two-stage chain.
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_relock_inc  = 1'b0;
    w_timeout_inc = 1'b0;
    case (r_state)
      RESET_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the final timeout cycle still wins.
        if (r_locked_s) begin
          w_state_nxt = STABILIZE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt   = RESET_PLL;
          w_cnt_nxt     = '0;
          w_timeout_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!r_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!r_locked_s) begin
          w_state_nxt  = RESET_PLL;
          w_relock_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge
  // as the state and never glitch.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state         <= RESET_PLL;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_core_reset    <= 1'b1;
      r_ready         <= 1'b0;
      r_relock_count  <= 8'd0;
      r_timeout_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pll_rst    <= (w_state_nxt == RESET_PLL);
      r_core_reset <= (w_state_nxt != RUN);
      r_ready      <= (w_state_nxt == RUN);
      if (w_relock_inc && (r_relock_count != 8'hFF)) begin
        r_relock_count <= r_relock_count + 8'd1;
      end
      if (w_timeout_inc && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign pll_rst       = r_pll_rst;
  assign core_reset    = r_core_reset;
  assign ready         = r_ready;
  assign relock_count  = r_relock_count;
  assign timeout_count = r_timeout_count;

endmodule
